// File: rtl/xgmac_tx_pkg.sv
// Shared widths and write-FSM encodings for the XGMAC TX frame buffer.
package xgmac_tx_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;
    // One stored word per beat: {tlast, tkeep, tdata}
    localparam int BUF_WORD_W  = 1 + AXIS_KEEP_W + AXIS_DATA_W;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_STORE = 2'd1,
        WR_DROP  = 2'd2
    } wr_state_t;

endpackage

// File: rtl/xgmac_tx_buf_ram.sv
// Simple dual-port frame storage: one write port, one registered read port.
// No reset so it maps onto block RAM.
module xgmac_tx_buf_ram
    import xgmac_tx_pkg::*;
#(
    parameter int ADDR_W = 9
)
(
    input  logic                  clk156,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [BUF_WORD_W-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [BUF_WORD_W-1:0] rd_data
);

    logic [BUF_WORD_W-1:0] mem [2**ADDR_W];

    // Write port and registered read port; rd_data holds while rd_en is low
    always_ff @(posedge clk156) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/xgmac_tx_frame_buffer.sv
// Store-and-forward AXI4-Stream TX frame buffer.
// Frames are released only after their tlast beat is stored; overflowing or
// tuser-flagged frames are discarded whole by rewinding the write pointer.
//
//  state    | meaning
//  WR_IDLE  | between frames; next accepted beat starts a frame
//  WR_STORE | mid-frame, beats written to RAM
//  WR_DROP  | mid-frame after overflow, beats discarded until tlast
module xgmac_tx_frame_buffer
    import xgmac_tx_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DROP_CNT_W = 16
)
(
    input  logic                   clk156,
    input  logic                   reset_n,
    input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_W-1:0] s_axis_tkeep,
    input  logic                   s_axis_tuser,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [AXIS_DATA_W-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_W-1:0] m_axis_tkeep,
    output logic                   m_axis_tuser,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [ADDR_W:0]        frame_count,
    output logic [DROP_CNT_W-1:0]  drop_count
);

    localparam int PTR_W = ADDR_W + 1;

    logic [1:0]            rst_sync;
    logic                  rst_n;
    wr_state_t             state, state_nxt;
    logic [PTR_W-1:0]      wr_ptr, wr_ptr_nxt, frame_start, frame_start_nxt;
    logic [PTR_W-1:0]      commit_ptr, rd_ptr;
    logic                  full, accept, we, commit, drop;
    logic                  tready_q, s1_vld, out_vld, out_load, rd_en;
    logic                  egress, egress_last;
    logic [BUF_WORD_W-1:0] rd_data, out_word;

    // Reset asserts asynchronously and releases two clocks after reset_n rises
    always_ff @(posedge clk156 or negedge reset_n) begin
        if (!reset_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign s_axis_tready = tready_q;
    assign accept        = s_axis_tvalid & tready_q;
    assign full          = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                           (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // Write FSM state register and pointers
    always_ff @(posedge clk156 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WR_IDLE;
            wr_ptr      <= '0;
            frame_start <= '0;
            commit_ptr  <= '0;
            tready_q    <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            frame_start <= frame_start_nxt;
            tready_q    <= 1'b1;
            if (commit) commit_ptr <= wr_ptr_nxt;
        end
    end

    // Next-state, write enable, commit and drop decisions
    always_comb begin
        state_nxt       = state;
        wr_ptr_nxt      = wr_ptr;
        frame_start_nxt = frame_start;
        we              = 1'b0;
        commit          = 1'b0;
        drop            = 1'b0;
        if (accept) begin
            case (state)
                WR_IDLE: begin
                    frame_start_nxt = wr_ptr;
                    if (full) begin
                        drop = 1'b1;
                        if (!s_axis_tlast) state_nxt = WR_DROP;
                    end else begin
                        we = 1'b1;
                        if (!s_axis_tlast) begin
                            wr_ptr_nxt = wr_ptr + PTR_W'(1);
                            state_nxt  = WR_STORE;
                        end else if (s_axis_tuser) begin
                            drop = 1'b1;
                        end else begin
                            commit     = 1'b1;
                            wr_ptr_nxt = wr_ptr + PTR_W'(1);
                        end
                    end
                end
                WR_STORE: begin
                    if (full) begin
                        drop       = 1'b1;
                        wr_ptr_nxt = frame_start;
                        state_nxt  = s_axis_tlast ? WR_IDLE : WR_DROP;
                    end else begin
                        we = 1'b1;
                        if (!s_axis_tlast) begin
                            wr_ptr_nxt = wr_ptr + PTR_W'(1);
                        end else begin
                            state_nxt = WR_IDLE;
                            if (s_axis_tuser) begin
                                drop       = 1'b1;
                                wr_ptr_nxt = frame_start;
                            end else begin
                                commit     = 1'b1;
                                wr_ptr_nxt = wr_ptr + PTR_W'(1);
                            end
                        end
                    end
                end
                WR_DROP: begin
                    if (s_axis_tlast) state_nxt = WR_IDLE;
                end
                default: state_nxt = WR_IDLE;
            endcase
        end
    end

    xgmac_tx_buf_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk156  (clk156),
        .wr_en   (we),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    // Read pipeline: RAM output register (s1) feeding the egress register
    assign egress      = out_vld & m_axis_tready;
    assign egress_last = egress & out_word[BUF_WORD_W-1];
    assign out_load    = s1_vld & (~out_vld | m_axis_tready);
    assign rd_en       = (rd_ptr != commit_ptr) & (~s1_vld | out_load);

    // Prefetch pointer and RAM-stage occupancy
    always_ff @(posedge clk156 or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            s1_vld <= 1'b0;
        end else if (rd_en) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            s1_vld <= 1'b1;
        end else if (out_load) begin
            s1_vld <= 1'b0;
        end
    end

    // Egress register; contents change only when empty or being handshaken
    always_ff @(posedge clk156 or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_word <= '0;
        end else if (out_load) begin
            out_vld  <= 1'b1;
            out_word <= rd_data;
        end else if (egress) begin
            out_vld  <= 1'b0;
        end
    end

    assign m_axis_tvalid = out_vld;
    assign m_axis_tdata  = out_word[AXIS_DATA_W-1:0];
    assign m_axis_tkeep  = out_word[AXIS_DATA_W +: AXIS_KEEP_W];
    assign m_axis_tlast  = out_word[BUF_WORD_W-1];
    assign m_axis_tuser  = 1'b0;

    // Stored-frame and saturating drop counters
    always_ff @(posedge clk156 or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (commit && !egress_last)      frame_count <= frame_count + PTR_W'(1);
            else if (!commit && egress_last) frame_count <= frame_count - PTR_W'(1);
            if (drop && (drop_count != '1))  drop_count  <= drop_count + DROP_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_xgmac_tx_frame_buffer.sv
// Directed and randomized bench for xgmac_tx_frame_buffer (ADDR_W=4, 16-beat buffer).
module tb_xgmac_tx_frame_buffer;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic        clk156, reset_n;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tuser, s_tvalid, s_tready, s_tlast;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tuser, m_tvalid, m_tready, m_tlast;
    logic [ADDR_W:0] frame_count;
    logic [15:0] drop_count;

    xgmac_tx_frame_buffer #(.ADDR_W(ADDR_W), .DROP_CNT_W(16)) dut (
        .clk156        (clk156),
        .reset_n       (reset_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .frame_count   (frame_count),
        .drop_count    (drop_count)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [72:0] exp_q[$];
    logic [63:0] frm_data[$];
    logic [7:0]  frm_keep[$];
    int          drop_exp = 0;
    int          fc_model = 0;
    bit          in_commit = 0;
    bit          mon_en = 0;
    bit          gap_chk = 0;
    int          rdy_mode = 0;

    bit          prev_stall = 0, prev_hs = 0, hs;
    logic [72:0] prev_word;

    initial begin
        clk156 = 0;
        forever #5 clk156 = ~clk156;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Egress ready: always high, 1,0,0,1 pattern, or random
    initial begin
        int cnt = 0;
        m_tready = 0;
        forever begin
            @(posedge clk156); #1;
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = ((cnt % 4) == 0) || ((cnt % 4) == 3);
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
            cnt++;
        end
    end

    // Egress monitor: beat order/content, hold while stalled, frame_count, tuser
    always @(negedge clk156) begin
        if (!reset_n) begin
            fc_model   = 0;
            prev_stall = 0;
            prev_hs    = 0;
        end else if (mon_en) begin
            chk("frame_count", 128'(frame_count), 128'(fc_model));
            chk("m_tuser", 128'(m_tuser), 128'(0));
            if (prev_stall)
                chk("hold_stalled", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, prev_word});
            if (gap_chk && prev_hs && exp_q.size() != 0)
                chk("no_bubble", 128'(m_tvalid), 128'(1));
            hs = m_tvalid && m_tready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL unexpected_beat: observed %h expected none", {m_tlast, m_tkeep, m_tdata});
                end else begin
                    chk("beat", {m_tlast, m_tkeep, m_tdata}, exp_q.pop_front());
                end
            end
            fc_model = fc_model + ((in_commit && s_tvalid && s_tready) ? 1 : 0)
                                - ((hs && m_tlast) ? 1 : 0);
            prev_stall = m_tvalid && !m_tready;
            prev_word  = {m_tlast, m_tkeep, m_tdata};
            prev_hs    = hs;
        end
    end

    task automatic build_frame(input int len);
        frm_data.delete();
        frm_keep.delete();
        for (int i = 0; i < len; i++) begin
            frm_data.push_back({$urandom, $urandom});
            frm_keep.push_back((i == len - 1) ? (8'hFF >> $urandom_range(0, 7)) : 8'hFF);
        end
    endtask

    // Drive the staged frame; the model decides its fate from length and tuser
    task automatic send_frame(input bit bad, input int gap_pct);
        int  n    = frm_data.size();
        bit  good = !bad && (n <= DEPTH);
        if (good) begin
            for (int i = 0; i < n; i++)
                exp_q.push_back({(i == n - 1), frm_keep[i], frm_data[i]});
        end else begin
            drop_exp++;
        end
        for (int i = 0; i < n; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) begin
                s_tvalid = 0;
                @(posedge clk156); #1;
            end
            s_tvalid  = 1;
            s_tdata   = frm_data[i];
            s_tkeep   = frm_keep[i];
            s_tlast   = (i == n - 1);
            s_tuser   = (i == n - 1) ? bad : 1'($urandom_range(0, 1));
            in_commit = (i == n - 1) && good;
            @(posedge clk156); #1;
        end
        s_tvalid  = 0;
        s_tlast   = 0;
        s_tuser   = 0;
        in_commit = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < 3000) begin
            @(posedge clk156); #1;
            n++;
        end
        chk("drain_in_time", 128'(n < 3000), 128'(1));
        repeat (3) begin @(posedge clk156); #1; end
        chk("drop_count", 128'(drop_count), 128'(drop_exp));
        chk("s_tready", 128'(s_tready), 128'(1));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!s_tready && n < 20) begin
            @(posedge clk156); #1;
            n++;
        end
        chk("tready_rise", 128'(n < 20), 128'(1));
    endtask

    initial begin
        reset_n  = 0;
        s_tvalid = 0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = 0;
        s_tlast  = 0;
        repeat (3) begin @(posedge clk156); #1; end
        chk("reset_outputs", {s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, frame_count, drop_count}, '0);
        reset_n = 1;
        wait_ready();
        mon_en = 1;

        // 1: 9-beat frame, tready high, check release latency
        gap_chk = 1;
        rdy_mode = 0;
        build_frame(8);
        frm_data.push_back(64'h71234567890ABEEF);
        frm_keep.push_back(8'h03);
        send_frame(0, 0);
        @(posedge clk156); #1;
        chk("tvalid_at_N+1", 128'(m_tvalid), 128'(0));
        @(posedge clk156); #1;
        chk("tvalid_at_N+2", 128'(m_tvalid), 128'(1));
        wait_drain();

        // 2: same frame under 1,0,0,1 back-pressure
        rdy_mode = 1;
        send_frame(0, 0);
        wait_drain();
        gap_chk = 0;

        // 3: oversize frame dropped, following frame intact
        rdy_mode = 0;
        build_frame(17);
        send_frame(0, 0);
        build_frame(9);
        send_frame(0, 0);
        wait_drain();

        // 4: tuser on tlast drops the frame
        build_frame(9);
        send_frame(1, 0);
        build_frame(9);
        send_frame(0, 0);
        wait_drain();

        // 5: back-to-back frames, egress overlapping next commit, no gap
        gap_chk = 1;
        build_frame(9);
        send_frame(0, 0);
        build_frame(9);
        send_frame(0, 0);
        wait_drain();
        gap_chk = 0;

        // Back-to-back short frames with occasional bad ones
        for (int f = 0; f < 8; f++) begin
            build_frame($urandom_range(1, 8));
            send_frame(($urandom_range(0, 3) == 0), 0);
        end
        wait_drain();

        // Randomized frames, random gaps and back-pressure, incl. boundary lengths
        rdy_mode = 2;
        for (int f = 0; f < 30; f++) begin
            build_frame((f < 3) ? (15 + f) : $urandom_range(1, 20));
            send_frame(($urandom_range(0, 5) == 0), 30);
            wait_drain();
        end

        // 6: reset during beat 4 of 9, then a clean frame
        rdy_mode = 0;
        build_frame(9);
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1;
            s_tdata  = frm_data[i];
            s_tkeep  = frm_keep[i];
            s_tlast  = 0;
            s_tuser  = 0;
            @(posedge clk156); #1;
        end
        s_tdata = frm_data[4];
        reset_n = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk156); #1;
            chk("outputs_in_reset", {s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, frame_count, drop_count}, '0);
        end
        s_tvalid = 0;
        drop_exp = 0;
        exp_q.delete();
        reset_n = 1;
        wait_ready();
        build_frame(9);
        send_frame(0, 0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
